// File: rtl/int_issue_queue_pkg.sv
// rtl/int_issue_queue_pkg.sv - shared dispatch/CDB/issue types and queue constants
package int_issue_queue_pkg;

  localparam int INT_IQ_DEPTH = 4;
  localparam int TAG_W        = 6;

  typedef struct packed {
    logic [TAG_W-1:0] rd_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_data;
    logic             rs1_data_valid;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_data;
    logic             rs2_data_valid;
  } common_fifo_data;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    common_fifo_data common;
  } int_fifo_data;

  typedef struct packed {
    logic         issue_rdy;
    int_fifo_data rsv_station_data;
  } int_issue_data;

  typedef struct packed {
    logic [TAG_W-1:0] cdb_tag;
    logic             cdb_valid;
    logic [31:0]      cdb_result;
    logic             cdb_branch;
    logic             cdb_branch_taken;
  } cdb_bfm;

  localparam int INT_FIFO_W  = $bits(int_fifo_data);
  localparam int INT_ISSUE_W = $bits(int_issue_data);
  localparam int CDB_W       = $bits(cdb_bfm);

endpackage

// File: rtl/iq_cdb_snoop.sv
// rtl/iq_cdb_snoop.sv - combinational CDB operand capture and readiness for one entry
// INT_IQ_CDB_BYPASS_EN: readiness also counts operands supplied by the current CDB.
module iq_cdb_snoop
  import int_issue_queue_pkg::*;
(
  input  logic [INT_FIFO_W-1:0] entry_in,
  input  logic [CDB_W-1:0]      cdb,
  output logic [INT_FIFO_W-1:0] entry_out,
  output logic                  ready
);

  int_fifo_data e;
  int_fifo_data upd;
  cdb_bfm       c;
  logic         rs1_hit;
  logic         rs2_hit;
  logic         unused_branch;

  assign e             = entry_in;
  assign c             = cdb;
  assign unused_branch = c.cdb_branch ^ c.cdb_branch_taken;

  assign rs1_hit = c.cdb_valid && !e.common.rs1_data_valid && (e.common.rs1_tag == c.cdb_tag);
  assign rs2_hit = c.cdb_valid && !e.common.rs2_data_valid && (e.common.rs2_tag == c.cdb_tag);

  always_comb begin
    upd = e;
    if (rs1_hit) begin
      upd.common.rs1_data       = c.cdb_result;
      upd.common.rs1_data_valid = 1'b1;
    end
    if (rs2_hit) begin
      upd.common.rs2_data       = c.cdb_result;
      upd.common.rs2_data_valid = 1'b1;
    end
  end

  assign entry_out = upd;

`ifdef INT_IQ_CDB_BYPASS_EN
  assign ready = upd.common.rs1_data_valid && upd.common.rs2_data_valid;
`else
  assign ready = e.common.rs1_data_valid && e.common.rs2_data_valid;
`endif

endmodule

// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - collapsing integer reservation station with CDB snoop and oldest-ready issue
// INT_IQ_CDB_BYPASS_EN: entries woken by the current CDB may issue in the same cycle.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = INT_IQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dispatch_en,
  input  logic [INT_FIFO_W-1:0]  dispatch_data,
  output logic                   queue_full,
  output logic                   queue_empty,
  input  logic [CDB_W-1:0]       cdb,
  output logic [INT_ISSUE_W-1:0] issue_data,
  input  logic                   issue_done,
  input  logic                   flush
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(DEPTH);

  int_fifo_data          slot_q     [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [CNT_W-1:0]      count_q;

  logic [INT_FIFO_W-1:0] slot_upd   [DEPTH];
  logic [DEPTH-1:0]      slot_rdy;
  logic [INT_FIFO_W-1:0] disp_upd;
  logic                  unused_disp_rdy;

  logic [INT_FIFO_W-1:0] shift_data [DEPTH];
  logic [DEPTH-1:0]      shift_valid;
  int_fifo_data          slot_d     [DEPTH];
  logic [DEPTH-1:0]      valid_d;
  logic [CNT_W-1:0]      count_d;

  logic                  found;
  logic [SEL_W-1:0]      sel;
  logic                  pop;
  logic                  wr;
  logic [CNT_W-1:0]      wr_idx;

  // Every stored slot plus the incoming dispatch is snooped against the same CDB.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot_snoop
    iq_cdb_snoop u_snoop (
      .entry_in  (slot_q[g]),
      .cdb       (cdb),
      .entry_out (slot_upd[g]),
      .ready     (slot_rdy[g])
    );
  end

  iq_cdb_snoop u_disp_snoop (
    .entry_in  (dispatch_data),
    .cdb       (cdb),
    .entry_out (disp_upd),
    .ready     (unused_disp_rdy)
  );

  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign queue_empty = (count_q == '0);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && valid_q[i] && slot_rdy[i]) begin
        found = 1'b1;
        sel   = SEL_W'(i);
      end
    end
  end

  assign issue_data = found ? {1'b1, slot_upd[sel]} : '0;

  assign pop    = issue_done && found && !flush;
  assign wr     = dispatch_en && !queue_full && !flush;
  assign wr_idx = count_q - CNT_W'(pop);

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shift_data[i]  = slot_upd[i+1];
      shift_valid[i] = valid_q[i+1];
    end
    shift_data[DEPTH-1]  = '0;
    shift_valid[DEPTH-1] = 1'b0;
  end

  // Collapse above the popped slot first, then place the new entry at the post-pop tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i]  = slot_upd[i];
      valid_d[i] = valid_q[i];
      if (pop && (i >= int'(sel))) begin
        slot_d[i]  = shift_data[i];
        valid_d[i] = shift_valid[i];
      end
      if (wr && (int'(wr_idx) == i)) begin
        slot_d[i]  = disp_upd;
        valid_d[i] = 1'b1;
      end
      if (flush) begin
        slot_d[i]  = '0;
        valid_d[i] = 1'b0;
      end
    end
    if (flush) count_d = '0;
    else       count_d = count_q + CNT_W'(wr) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - table, corner-sequence and random-vs-model bench for int_issue_queue
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   dispatch_en;
  logic [INT_FIFO_W-1:0]  dispatch_data;
  logic                   queue_full;
  logic                   queue_empty;
  logic [CDB_W-1:0]       cdb;
  logic [INT_ISSUE_W-1:0] issue_data;
  logic                   issue_done;
  logic                   flush;

  int checks   = 0;
  int failures = 0;
  int_fifo_data mq[$];

  always #5 clk = ~clk;

  int_issue_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dispatch_en   (dispatch_en),
    .dispatch_data (dispatch_data),
    .queue_full    (queue_full),
    .queue_empty   (queue_empty),
    .cdb           (cdb),
    .issue_data    (issue_data),
    .issue_done    (issue_done),
    .flush         (flush)
  );

  typedef struct {
    logic         de;
    int_fifo_data d;
    cdb_bfm       c;
    logic         done;
    logic         fl;
    logic         exp_rdy;
    logic [31:0]  exp_rs1;
    logic [31:0]  exp_rs2;
    logic         exp_full;
    logic         exp_empty;
  } vec_t;

  vec_t vt[16];

  function automatic int_fifo_data mk(input logic [5:0] rd, input logic [5:0] t1, input logic [31:0] d1,
                                      input logic v1, input logic [5:0] t2, input logic [31:0] d2, input logic v2);
    int_fifo_data e;
    e = '0;
    e.opcode                = 7'h33;
    e.func3                 = 3'd2;
    e.func7                 = 7'h20;
    e.common.rd_tag         = rd;
    e.common.wb_valid       = 1'b1;
    e.common.rs1_tag        = t1;
    e.common.rs1_data       = d1;
    e.common.rs1_data_valid = v1;
    e.common.rs2_tag        = t2;
    e.common.rs2_data       = d2;
    e.common.rs2_data_valid = v2;
    return e;
  endfunction

  function automatic cdb_bfm mkcdb(input logic v, input logic [5:0] t, input logic [31:0] r);
    cdb_bfm c;
    c = '0;
    c.cdb_valid  = v;
    c.cdb_tag    = t;
    c.cdb_result = r;
    return c;
  endfunction

  // Reference behaviour: an age-ordered list; operands captured from the CDB by tag.
  function automatic int_fifo_data m_snoop(input int_fifo_data e, input cdb_bfm c);
    int_fifo_data r;
    r = e;
    if (c.cdb_valid && !e.common.rs1_data_valid && e.common.rs1_tag == c.cdb_tag) begin
      r.common.rs1_data = c.cdb_result; r.common.rs1_data_valid = 1'b1;
    end
    if (c.cdb_valid && !e.common.rs2_data_valid && e.common.rs2_tag == c.cdb_tag) begin
      r.common.rs2_data = c.cdb_result; r.common.rs2_data_valid = 1'b1;
    end
    return r;
  endfunction

  function automatic logic m_ready(input int_fifo_data e, input cdb_bfm c);
    int_fifo_data r;
`ifdef INT_IQ_CDB_BYPASS_EN
    r = m_snoop(e, c);
`else
    r = e;
`endif
    return r.common.rs1_data_valid && r.common.rs2_data_valid;
  endfunction

  function automatic int m_select(input cdb_bfm c);
    for (int i = 0; i < mq.size(); i++) if (m_ready(mq[i], c)) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic de, input int_fifo_data d, input cdb_bfm c, input logic done, input logic fl);
    dispatch_en   = de;
    dispatch_data = d;
    cdb           = c;
    issue_done    = done;
    flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_edge();
    int_fifo_data d;
    cdb_bfm       c;
    int           s;
    int           pre;
    d = dispatch_data;
    c = cdb;
    if (!rst_n || flush) begin
      mq.delete();
      return;
    end
    s   = m_select(c);
    pre = mq.size();
    for (int i = 0; i < mq.size(); i++) mq[i] = m_snoop(mq[i], c);
    if (issue_done && s >= 0) mq.delete(s);
    if (dispatch_en && pre < INT_IQ_DEPTH) mq.push_back(m_snoop(d, c));
  endtask

  task automatic finish_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int cyc);
    int_issue_data exp;
    int            s;
    s   = m_select(cdb);
    exp = '0;
    if (s >= 0) begin
      exp.issue_rdy        = 1'b1;
      exp.rsv_station_data = m_snoop(mq[s], cdb);
    end
    chk($sformatf("rnd%0d.issue_data", cyc), issue_data, exp);
    chk($sformatf("rnd%0d.full", cyc), queue_full, mq.size() == INT_IQ_DEPTH);
    chk($sformatf("rnd%0d.empty", cyc), queue_empty, mq.size() == 0);
  endtask

  task automatic chk_head(input string name, input logic rdy, input logic [31:0] rs1);
    int_issue_data id;
    id = issue_data;
    chk({name, ".rdy"}, id.issue_rdy, rdy);
    if (rdy) chk({name, ".rs1"}, id.rsv_station_data.common.rs1_data, rs1);
    else     chk({name, ".bus"}, issue_data, '0);
  endtask

  initial begin
    int_issue_data id;
    int_fifo_data  rd;
    cdb_bfm        rc;

    // Columns: de, data, cdb, done, flush | rdy, rs1, rs2, full, empty (outputs before the edge)
    vt[0]  = '{1'b0, '0, '0, 1'b0, 1'b0,                                          1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vt[1]  = '{1'b1, mk(6'd5, 6'd1, 32'd10, 1'b1, 6'd2, 32'd20, 1'b1), '0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vt[2]  = '{1'b0, '0, '0, 1'b0, 1'b0,                                          1'b1, 32'd10, 32'd20, 1'b0, 1'b0};
    vt[3]  = '{1'b0, '0, '0, 1'b1, 1'b0,                                          1'b1, 32'd10, 32'd20, 1'b0, 1'b0};
    vt[4]  = '{1'b0, '0, '0, 1'b0, 1'b0,                                          1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vt[5]  = '{1'b1, mk(6'd8, 6'd3, 32'h0, 1'b0, 6'd4, 32'h2, 1'b1), '0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vt[6]  = '{1'b1, mk(6'd9, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 1'b1), '0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, '0, '0, 1'b0, 1'b0,                                          1'b1, 32'h11, 32'h22, 1'b0, 1'b0};
    vt[8]  = '{1'b0, '0, '0, 1'b1, 1'b0,                                          1'b1, 32'h11, 32'h22, 1'b0, 1'b0};
`ifdef INT_IQ_CDB_BYPASS_EN
    vt[9]  = '{1'b0, '0, mkcdb(1'b1, 6'd3, 32'hAB), 1'b0, 1'b0,                  1'b1, 32'hAB, 32'h2, 1'b0, 1'b0};
`else
    vt[9]  = '{1'b0, '0, mkcdb(1'b1, 6'd3, 32'hAB), 1'b0, 1'b0,                  1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
`endif
    vt[10] = '{1'b0, '0, '0, 1'b1, 1'b0,                                          1'b1, 32'hAB, 32'h2, 1'b0, 1'b0};
    vt[11] = '{1'b0, '0, '0, 1'b0, 1'b0,                                          1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vt[12] = '{1'b1, mk(6'd6, 6'd1, 32'h1, 1'b1, 6'd7, 32'h0, 1'b0), mkcdb(1'b1, 6'd7, 32'h55), 1'b0, 1'b0,
               1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vt[13] = '{1'b0, '0, '0, 1'b0, 1'b0,                                          1'b1, 32'h1, 32'h55, 1'b0, 1'b0};
    vt[14] = '{1'b0, '0, '0, 1'b1, 1'b0,                                          1'b1, 32'h1, 32'h55, 1'b0, 1'b0};
    vt[15] = '{1'b0, '0, '0, 1'b0, 1'b0,                                          1'b0, 32'h0, 32'h0, 1'b0, 1'b1};

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.full", queue_full, 1'b0);
    chk("reset.empty", queue_empty, 1'b1);
    chk("reset.issue_data", issue_data, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].de, vt[i].d, vt[i].c, vt[i].done, vt[i].fl);
      @(negedge clk);
      id = issue_data;
      chk($sformatf("vec%0d.rdy", i), id.issue_rdy, vt[i].exp_rdy);
      if (vt[i].exp_rdy) begin
        chk($sformatf("vec%0d.rs1", i), id.rsv_station_data.common.rs1_data, vt[i].exp_rs1);
        chk($sformatf("vec%0d.rs2", i), id.rsv_station_data.common.rs2_data, vt[i].exp_rs2);
      end else begin
        chk($sformatf("vec%0d.bus", i), issue_data, '0);
      end
      chk($sformatf("vec%0d.full", i), queue_full, vt[i].exp_full);
      chk($sformatf("vec%0d.empty", i), queue_empty, vt[i].exp_empty);
      finish_cycle();
    end

    // Fill, reject while full (also alongside a pop), then drain in order.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, mk(6'(k), 6'd0, 32'(100 + k), 1'b1, 6'd0, 32'(1000 + k), 1'b1), '0, 1'b0, 1'b0);
      finish_cycle();
    end
    drive(1'b1, mk(6'd9, 6'd0, 32'd999, 1'b1, 6'd0, 32'd999, 1'b1), '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full.flag", queue_full, 1'b1);
    chk_head("full.head", 1'b1, 32'd100);
    finish_cycle();
    drive(1'b1, mk(6'd9, 6'd0, 32'd200, 1'b1, 6'd0, 32'd200, 1'b1), '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("full.reject_flag", queue_full, 1'b1);
    chk_head("full.reject_head", 1'b1, 32'd100);
    finish_cycle();
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("drain%0d.full", k), queue_full, 1'b0);
      chk_head($sformatf("drain%0d", k), 1'b1, 32'(100 + k));
      finish_cycle();
    end
    idle();
    @(negedge clk);
    chk("drain.empty", queue_empty, 1'b1);
    chk_head("drain.idle", 1'b0, 32'd0);
    finish_cycle();

    // Flush with a concurrent dispatch leaves the queue empty.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mk(6'(k), 6'(10 + k), 32'd0, 1'b0, 6'd0, 32'd1, 1'b1), '0, 1'b0, 1'b0);
      finish_cycle();
    end
    drive(1'b1, mk(6'd3, 6'd0, 32'd7, 1'b1, 6'd0, 32'd8, 1'b1), '0, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush.pre_empty", queue_empty, 1'b0);
    chk_head("flush.pre", 1'b0, 32'd0);
    finish_cycle();
    idle();
    @(negedge clk);
    chk("flush.empty", queue_empty, 1'b1);
    chk_head("flush.post", 1'b0, 32'd0);
    finish_cycle();

    // Asynchronous reset between edges.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, mk(6'(k), 6'd0, 32'(50 + k), 1'b1, 6'd0, 32'd0, 1'b1), '0, 1'b0, 1'b0);
      finish_cycle();
    end
    idle();
    #2;
    chk("areset.before_empty", queue_empty, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("areset.empty", queue_empty, 1'b1);
    chk("areset.full", queue_full, 1'b0);
    chk("areset.issue_data", issue_data, '0);
    mq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rd = mk(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), $urandom, 1'($urandom),
              6'($urandom_range(0, 7)), $urandom, 1'($urandom));
      rd.common.wb_valid = 1'($urandom);
      rd.func3           = 3'($urandom);
      rc = mkcdb(1'($urandom), 6'($urandom_range(0, 7)), $urandom);
      rc.cdb_branch       = 1'($urandom);
      rc.cdb_branch_taken = 1'($urandom);
      drive(($urandom_range(0, 2) != 0), rd, rc, 1'($urandom), ($urandom_range(0, 49) == 0));
      @(negedge clk);
      check_model(cyc);
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
